// File: rtl/decoder_scan_ctrl.sv
// Select-bus scan controller for a 2**N-output one-hot decoder: walks first..last with a per-code dwell.
// Optional freeze input `pause` is compiled in with DECODER_SCAN_PAUSE_EN.
module decoder_scan_ctrl #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [N-1:0]       first,
  input  logic [N-1:0]       last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
`ifdef DECODER_SCAN_PAUSE_EN
  input  logic               pause,
`endif
  output logic [N-1:0]       sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               step,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [N-1:0]       SEL_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_nx_s;

  logic [N-1:0]         sel_r;
  logic [N-1:0]         sel_nx_s;
  logic                 sel_valid_r;
  logic                 sel_valid_nx_s;
  logic                 busy_r;
  logic                 busy_nx_s;
  logic                 step_r;
  logic                 step_nx_s;
  logic                 done_r;
  logic                 done_nx_s;
  logic [DWELL_W-1:0]   cnt_r;
  logic [DWELL_W-1:0]   cnt_nx_s;

  logic                 dir_r;
  logic [N-1:0]         first_r;
  logic [N-1:0]         last_r;
  logic [DWELL_W-1:0]   dwell_r;
  logic                 loop_r;

  logic                 load_cfg_s;
  logic                 launch_s;
  logic                 expire_s;
  logic                 at_last_s;
  logic                 pause_s;

  // Neighbouring code in the scan direction; wraps modulo 2**N.
  function automatic logic [N-1:0] next_code(input logic [N-1:0] cur, input logic down);
    if (down) begin
      next_code = cur - SEL_ONE;
    end else begin
      next_code = cur + SEL_ONE;
    end
  endfunction

`ifdef DECODER_SCAN_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign launch_s  = start & ~stop;
  assign expire_s  = (cnt_r == {DWELL_W{1'b0}});
  assign at_last_s = (sel_r == last_r);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode; stop outranks pause, expiry and loop restart
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx_s = IDLE;
        end else if (pause_s) begin
          state_nx_s = RUN;
        end else if (expire_s && at_last_s && !loop_r) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = RUN;
        end
      end
      FIN: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM output decode: next values for the registered outputs and dwell counter
  always_comb begin
    sel_nx_s       = sel_r;
    sel_valid_nx_s = sel_valid_r;
    busy_nx_s      = busy_r;
    step_nx_s      = 1'b0;
    done_nx_s      = 1'b0;
    cnt_nx_s       = cnt_r;
    load_cfg_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          load_cfg_s     = 1'b1;
          sel_nx_s       = first;
          sel_valid_nx_s = 1'b1;
          busy_nx_s      = 1'b1;
          cnt_nx_s       = dwell;
        end else begin
          sel_valid_nx_s = 1'b0;
          busy_nx_s      = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          sel_valid_nx_s = 1'b0;
          busy_nx_s      = 1'b0;
        end else if (pause_s) begin
          cnt_nx_s = cnt_r;
        end else if (!expire_s) begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end else if (!at_last_s) begin
          sel_nx_s  = next_code(sel_r, dir_r);
          cnt_nx_s  = dwell_r;
          step_nx_s = 1'b1;
        end else if (loop_r) begin
          sel_nx_s  = first_r;
          cnt_nx_s  = dwell_r;
          step_nx_s = 1'b1;
        end else begin
          sel_valid_nx_s = 1'b0;
          busy_nx_s      = 1'b0;
          done_nx_s      = 1'b1;
        end
      end
      FIN: begin
        sel_valid_nx_s = 1'b0;
        busy_nx_s      = 1'b0;
      end
      default: begin
        sel_valid_nx_s = 1'b0;
        busy_nx_s      = 1'b0;
        cnt_nx_s       = {DWELL_W{1'b0}};
      end
    endcase
  end

  // Output and dwell-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= {N{1'b0}};
      sel_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      step_r      <= 1'b0;
      done_r      <= 1'b0;
      cnt_r       <= {DWELL_W{1'b0}};
    end else begin
      sel_r       <= sel_nx_s;
      sel_valid_r <= sel_valid_nx_s;
      busy_r      <= busy_nx_s;
      step_r      <= step_nx_s;
      done_r      <= done_nx_s;
      cnt_r       <= cnt_nx_s;
    end
  end

  // Scan settings captured once per launch so mid-scan input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r   <= 1'b0;
      first_r <= {N{1'b0}};
      last_r  <= {N{1'b0}};
      dwell_r <= {DWELL_W{1'b0}};
      loop_r  <= 1'b0;
    end else if (load_cfg_s) begin
      dir_r   <= dir;
      first_r <= first;
      last_r  <= last;
      dwell_r <= dwell;
      loop_r  <= loop;
    end else begin
      dir_r   <= dir_r;
      first_r <= first_r;
      last_r  <= last_r;
      dwell_r <= dwell_r;
      loop_r  <= loop_r;
    end
  end

  assign sel       = sel_r;
  assign sel_valid = sel_valid_r;
  assign busy      = busy_r;
  assign step      = step_r;
  assign done      = done_r;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: stimulus queues expected per-cycle outputs, a negedge monitor pops and compares.
module tb_decoder_scan_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic       step;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       dir;
  logic [2:0] first;
  logic [2:0] last;
  logic [7:0] dwell;
  logic       loop;
  logic       pause;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       step;
  logic       done;

  exp_t q[$];
  int   n_cmp;
  int   n_fail;

  decoder_scan_ctrl #(.N(3), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .first     (first),
    .last      (last),
    .dwell     (dwell),
    .loop      (loop),
`ifdef DECODER_SCAN_PAUSE_EN
    .pause     (pause),
`endif
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .step      (step),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle the DUT presents activity, compare against the head of the queue
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (rst_n && (sel_valid || busy || step || done)) begin
      act = '{sel, sel_valid, busy, step, done};
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output t=%0t act{sel,valid,busy,step,done}=%h required=none", $time, act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL scan_out t=%0t act{sel,valid,busy,step,done}=%h required=%h", $time, act, e);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic push_code(input logic [2:0] code, input int hold, input logic first_code);
    for (int i = 0; i < hold; i++) begin
      q.push_back('{code, 1'b1, 1'b1, (i == 0) && !first_code, 1'b0});
    end
  endtask

  task automatic push_done(input logic [2:0] code);
    q.push_back('{code, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic launch(input logic [2:0] f, input logic [2:0] l, input logic d,
                        input logic [7:0] dw, input logic lp);
    @(negedge clk);
    first = f; last = l; dir = d; dwell = dw; loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int c;
    c = 0;
    while (q.size() != 0 && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    check({name, "_drained"}, q.size(), 0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; pause = 1'b0;
    first = 3'd0; last = 3'd0; dwell = 8'd0; loop = 1'b0;

    #12;
    check("rst_sel", sel, 0);
    check("rst_sel_valid", sel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_step", step, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full range up, one cycle per code
    push_code(3'd0, 1, 1'b1);
    for (int c = 1; c < 8; c++) push_code(3'(c), 1, 1'b0);
    push_done(3'd7);
    launch(3'd0, 3'd7, 1'b0, 8'd0, 1'b0);
    drain("full_up", 40);
    check("full_up_sel_valid_after", sel_valid, 0);

    // down 5..2 with dwell 2
    push_code(3'd5, 3, 1'b1);
    push_code(3'd4, 3, 1'b0);
    push_code(3'd3, 3, 1'b0);
    push_code(3'd2, 3, 1'b0);
    push_done(3'd2);
    launch(3'd5, 3'd2, 1'b1, 8'd2, 1'b0);
    drain("down_dwell2", 40);

    // wrap with loop, stop while sel=0
    push_code(3'd6, 1, 1'b1);
    push_code(3'd7, 1, 1'b0);
    push_code(3'd0, 1, 1'b0);
    @(negedge clk);
    first = 3'd6; last = 3'd1; dir = 1'b0; dwell = 8'd0; loop = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_sel_valid", sel_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    drain("wrap_stop", 10);
    loop = 1'b0;

    // start and stop together in IDLE
    @(negedge clk);
    first = 3'd2; last = 3'd4; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_sel_valid", sel_valid, 0);
    repeat (3) @(negedge clk);

    // start pulsed mid-scan with different settings is ignored
    push_code(3'd1, 2, 1'b1);
    push_code(3'd2, 2, 1'b0);
    push_code(3'd3, 2, 1'b0);
    push_done(3'd3);
    launch(3'd1, 3'd3, 1'b0, 8'd1, 1'b0);
    first = 3'd5; last = 3'd0; dir = 1'b1; dwell = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("restart_ignored", 30);

    // async reset mid-dwell while sel=3
    push_code(3'd3, 2, 1'b1);
    launch(3'd3, 3'd5, 1'b0, 8'd5, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", sel, 0);
    check("async_rst_sel_valid", sel_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain("async_rst", 5);

    // single code first=last=4, dwell 3
    push_code(3'd4, 4, 1'b1);
    push_done(3'd4);
    launch(3'd4, 3'd4, 1'b0, 8'd3, 1'b0);
    drain("single_code", 20);

`ifdef DECODER_SCAN_PAUSE_EN
    // pause for 5 cycles while sel=2 stretches it to 7 cycles
    push_code(3'd0, 2, 1'b1);
    push_code(3'd1, 2, 1'b0);
    push_code(3'd2, 7, 1'b0);
    push_code(3'd3, 2, 1'b0);
    push_code(3'd4, 2, 1'b0);
    push_code(3'd5, 2, 1'b0);
    push_done(3'd5);
    @(negedge clk);
    first = 3'd0; last = 3'd5; dir = 1'b0; dwell = 8'd1; loop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    pause = 1'b1;
    repeat (5) @(negedge clk);
    pause = 1'b0;
    drain("pause", 40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
